// File: rtl/periph_spi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | periph_spi_pkg : shared FSM state and latched-config types  Rev 1.0|
// +--------------------------------------------------------------------+
package periph_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
    logic cs_hold;
  } spi_cfg_t;

endpackage
`default_nettype wire

// File: rtl/periph_spi_master_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | periph_spi_master_if : CPU-side request bus and SPI pins   Rev 1.0 |
// +--------------------------------------------------------------------+
interface periph_spi_master_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 1,
  parameter int DIV_W  = 8
);
  localparam int SEL_W = $clog2(NUM_CS) + 1;

  logic              start_in;
  logic [DATA_W-1:0] tx_data_in;
  logic [SEL_W-1:0]  cs_sel_in;
  logic [DIV_W-1:0]  div_in;
  logic              cpol_in;
  logic              cpha_in;
  logic              lsb_first_in;
  logic              cs_hold_in;
  logic              cs_release_in;
  logic              busy_out;
  logic              done_out;
  logic [DATA_W-1:0] rx_data_out;
  logic              sclk_out;
  logic              mosi_out;
  logic              miso_in;
  logic [NUM_CS-1:0] cs_out;

  modport master (
    output start_in, tx_data_in, cs_sel_in, div_in, cpol_in, cpha_in,
           lsb_first_in, cs_hold_in, cs_release_in, miso_in,
    input  busy_out, done_out, rx_data_out, sclk_out, mosi_out, cs_out
  );

  modport slave (
    input  start_in, tx_data_in, cs_sel_in, div_in, cpol_in, cpha_in,
           lsb_first_in, cs_hold_in, cs_release_in, miso_in,
    output busy_out, done_out, rx_data_out, sclk_out, mosi_out, cs_out
  );

endinterface
`default_nettype wire

// File: rtl/periph_spi_clkdiv.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | periph_spi_clkdiv : tick every div_in+1 cycles, restartable Rev 1.0|
// +--------------------------------------------------------------------+
module periph_spi_clkdiv #(
  parameter int DIV_W = 8
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             restart_in,
  input  logic [DIV_W-1:0] div_in,
  output logic             tick_out
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Counter never passes div_in, so an all-ones divider cannot wrap early.
  always_comb begin
    tick_out = !restart_in && (cnt_q == div_in);
    cnt_d    = (restart_in || tick_out) ? '0 : cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/periph_spi_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | periph_spi_master : 4-mode SPI master with multi-CS and CS hold    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module periph_spi_master
  import periph_spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 1,
  parameter int DIV_W  = 8
) (
  input  logic               clk_in,
  input  logic               reset_in,
  periph_spi_master_if.slave bus
);

  localparam int SEL_W = $clog2(NUM_CS) + 1;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT_CPHA0 = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT_CPHA1 = CNT_W'(DATA_W - 1);

  spi_state_t        state_q, state_d;
  spi_cfg_t          cfg_q, cfg_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_sh_q, rx_sh_d, rx_q, rx_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              phase_q, phase_d, sclk_q, sclk_d;
  logic              mosi_q, mosi_d, done_q, done_d;
  logic [NUM_CS-1:0] cs_q, cs_d, cs_sel_dec;
  logic              tick, accept, sample_edge, drive_edge, last_edge;
  logic              tx_first, tx_in_first;
  logic [DATA_W-1:0] tx_shift, tx_in_shift;

  periph_spi_clkdiv #(.DIV_W(DIV_W)) u_clkdiv (
    .clk_in     (clk_in),
    .reset_in   (reset_in),
    .restart_in (accept),
    .div_in     (div_q),
    .tick_out   (tick)
  );

  assign accept      = (state_q == IDLE) && bus.start_in;
  assign tx_first    = cfg_q.lsb_first ? tx_q[0] : tx_q[DATA_W-1];
  assign tx_shift    = cfg_q.lsb_first ? (tx_q >> 1) : (tx_q << 1);
  assign tx_in_first = bus.lsb_first_in ? bus.tx_data_in[0] : bus.tx_data_in[DATA_W-1];
  assign tx_in_shift = bus.lsb_first_in ? (bus.tx_data_in >> 1) : (bus.tx_data_in << 1);

  // phase_q=0 marks an odd edge; cpha selects which parity samples.
  assign sample_edge = (phase_q == cfg_q.cpha);
  assign last_edge   = phase_q &&
                       (bit_cnt_q == (cfg_q.cpha ? LAST_CNT_CPHA1 : LAST_CNT_CPHA0));
  assign drive_edge  = !sample_edge && !last_edge;

  always_comb begin
    cs_sel_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      cs_sel_dec[i] = (bus.cs_sel_in != SEL_W'(i));
    end
  end

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    div_d     = div_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_d      = rx_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_d      = cs_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cfg_d     = '{cpol: bus.cpol_in, cpha: bus.cpha_in,
                        lsb_first: bus.lsb_first_in, cs_hold: bus.cs_hold_in};
          div_d     = bus.div_in;
          tx_d      = bus.tx_data_in;
          sclk_d    = bus.cpol_in;
          bit_cnt_d = '0;
          phase_d   = 1'b0;
          cs_d      = cs_sel_dec;
          state_d   = LEAD;
          if (!bus.cpha_in) begin
            mosi_d = tx_in_first;
            tx_d   = tx_in_shift;
          end
        end else if (bus.cs_release_in) begin
          cs_d = '1;
        end
      end
      LEAD: begin
        if (tick) state_d = XFER;
      end
      XFER: begin
        if (tick) begin
          sclk_d  = !sclk_q;
          phase_d = !phase_q;
          if (sample_edge) begin
            rx_sh_d   = cfg_q.lsb_first ? {bus.miso_in, rx_sh_q[DATA_W-1:1]}
                                        : {rx_sh_q[DATA_W-2:0], bus.miso_in};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
          if (drive_edge) begin
            mosi_d = tx_first;
            tx_d   = tx_shift;
          end
          if (last_edge) state_d = TRAIL;
        end
      end
      TRAIL: begin
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
          rx_d    = rx_sh_q;
          if (!cfg_q.cs_hold) cs_d = '1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q   <= IDLE;
      cfg_q     <= '0;
      div_q     <= '0;
      tx_q      <= '0;
      rx_sh_q   <= '0;
      rx_q      <= '0;
      bit_cnt_q <= '0;
      phase_q   <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_q      <= '1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      div_q     <= div_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      rx_q      <= rx_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_q      <= cs_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy_out    = (state_q != IDLE);
  assign bus.done_out    = done_q;
  assign bus.rx_data_out = rx_q;
  assign bus.sclk_out    = sclk_q;
  assign bus.mosi_out    = mosi_q;
  assign bus.cs_out      = cs_q;

endmodule
`default_nettype wire
